// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- multi-cycle ALU for the CPU execute stage.
//
// Logic ops and add/sub/inc/dec finish in one cycle. MUL runs an iterative
// shift-add unit and DIV runs a restoring divider. Each of these takes WIDTH
// iterations. Both sides of the unit use a valid/ready handshake. Result and
// flags are registered, and they change only when the FSM enters DONE.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; operands are latched on accept
//   A, B                    unsigned operands (WIDTH bits)
//   ALUControl              opcode (OPW bits)
//   out_valid / out_ready   result handshake; out_valid is high only in DONE
//   Result                  registered result (WIDTH bits)
//   Negative, Zero          derived from Result
//   Carry                   carry (ADD/INC) or borrow (SUB/DEC), else 0
//   DivByZero               DIV was issued with B == 0
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 19,
    parameter int OPW   = 5,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Negative,
    output logic             Zero,
    output logic             Carry,
    output logic             DivByZero
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV = OPW'(3);
    localparam logic [OPW-1:0] OP_INC = OPW'(4);
    localparam logic [OPW-1:0] OP_DEC = OPW'(5);
    localparam logic [OPW-1:0] OP_AND = OPW'(6);
    localparam logic [OPW-1:0] OP_OR  = OPW'(7);
    localparam logic [OPW-1:0] OP_XOR = OPW'(8);
    localparam logic [OPW-1:0] OP_NOT = OPW'(9);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    // acc holds the MUL accumulator or the DIV partial remainder.
    // opa holds the MUL multiplier (shifts right) or the DIV dividend,
    // which becomes the quotient as it shifts left.
    // opb holds the MUL multiplicand (shifts left) or the DIV divisor.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic [WIDTH:0]   sc_wide;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign Result    = result_q;
    assign Carry     = carry_q;
    assign DivByZero = dbz_q;
    assign Negative  = result_q[WIDTH-1];
    assign Zero      = (result_q == '0);

    // Single-cycle datapath. The extra top bit of sc_wide is the carry or borrow.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        sc_wide   = '0;
        sc_result = '0;
        sc_carry  = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                sc_wide   = {1'b0, A} + {1'b0, B};
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_SUB: begin
                sc_wide   = {1'b0, A} - {1'b0, B};
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_INC: begin
                sc_wide   = {1'b0, A} + (WIDTH+1)'(1);
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_DEC: begin
                sc_wide   = {1'b0, A} - (WIDTH+1)'(1);
                sc_result = sc_wide[WIDTH-1:0];
                sc_carry  = sc_wide[WIDTH];
            end
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            OP_NOT:  sc_result = ~A;
            default: sc_result = '0;
        endcase
    end

    // One iteration of each multi-cycle unit.
    // For DIV, the partial remainder is always below the divisor, so the
    // shifted value needs one extra bit. When the trial subtraction succeeds,
    // the difference fits back into WIDTH bits, and bit WIDTH of the
    // difference acts as the borrow.
    always_comb begin
        mul_sum   = acc_q + (opa_q[0] ? opb_q : '0);
        div_shift = {acc_q, opa_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ok    = ~div_diff[WIDTH];
        rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {opa_q[WIDTH-2:0], div_ok};
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ALUControl == OP_MUL) begin
                        acc_d   = '0;
                        opa_d   = B;
                        opb_d   = A;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else if (ALUControl == OP_DIV) begin
                        if (B == '0) begin
                            result_d = '0;
                            carry_d  = 1'b0;
                            dbz_d    = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = '0;
                            opa_d   = A;
                            opb_d   = B;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
                    end else begin
                        result_d = sc_result;
                        carry_d  = sc_carry;
                        dbz_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                opa_d = opa_q >> 1;
                opb_d = opb_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    result_d = mul_sum;
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = rem_next;
                opa_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    result_d = quo_next;
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well, so no opcode can expose X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH=19).
// An arithmetic reference model computes the expected result, flags and
// latency for each operation. The stimulus is a directed sequence followed
// by randomized operations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_alu;

    localparam int W = 19;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [4:0]   op_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         carry;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W), .OPW(5), .CNTW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (a_in),
        .B          (b_in),
        .ALUControl (op_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (result),
        .Negative   (negative),
        .Zero       (zero),
        .Carry      (carry),
        .DivByZero  (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected result, flags and latency from plain arithmetic.
    function automatic void model(input logic [4:0] op, input longint unsigned a, input longint unsigned b,
                                  output longint unsigned res, output bit c, output bit dz, output int lat);
        res = 0; c = 0; dz = 0; lat = 1;
        case (op)
            5'd0: begin res = a + b; c = (res > MASK); end
            5'd1: begin c = (a < b); res = a - b; end
            5'd2: begin res = a * b; lat = W + 1; end
            5'd3: begin
                if (b == 0) dz = 1;
                else begin res = a / b; lat = W + 1; end
            end
            5'd4: begin res = a + 1; c = (res > MASK); end
            5'd5: begin c = (a == 0); res = a - 1; end
            5'd6: res = a & b;
            5'd7: res = a | b;
            5'd8: res = a ^ b;
            5'd9: res = ~a;
            default: res = 0;
        endcase
        res = res & MASK;
    endfunction

    // Issue one op, hold out_ready low for 'hold' cycles in DONE, then release.
    // Entry and exit points are 1 ns after a rising edge.
    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string tag);
        longint unsigned exp_res;
        bit exp_c, exp_dz;
        int exp_lat, lat;
        model(op, a, b, exp_res, exp_c, exp_dz, exp_lat);
        op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        @(posedge clk); #1;
        // Garbage with in_valid high while busy must be ignored.
        in_valid = 1'b1;
        a_in = W'($urandom); b_in = W'($urandom); op_in = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".carry"}, carry, exp_c);
        check({tag, ".dbz"}, dbz, exp_dz);
        check({tag, ".zero"}, zero, exp_res == 0);
        check({tag, ".neg"}, negative, (exp_res >> (W - 1)) & 1);
        check({tag, ".in_ready_busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".held_valid"}, out_valid, 1);
            check({tag, ".held_result"}, result, exp_res);
            check({tag, ".held_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".released"}, out_valid, 0);
        check({tag, ".back_idle"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0; out_ready = 1'b1;
        #2;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 0);
        check("rst.result", result, 0);
        check("rst.carry", carry, 0);
        check("rst.dbz", dbz, 0);
        check("rst.zero", zero, 1);
        check("rst.neg", negative, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.in_ready", in_ready, 1);

        // Directed cases.
        do_op(5'd0, 19'h7FFFF, 19'd1, 0, "add_wrap");
        do_op(5'd1, 19'd5, 19'd7, 0, "sub_borrow");
        do_op(5'd2, 19'd1000, 19'd300, 0, "mul");
        do_op(5'd2, 19'h40000, 19'd2, 0, "mul_ovf");
        do_op(5'd3, 19'd100000, 19'd7, 0, "div");
        do_op(5'd3, 19'd9, 19'd0, 0, "div0");
        do_op(5'd3, 19'd3, 19'd9, 0, "div_small");
        do_op(5'd3, 19'h7FFFF, 19'd1, 0, "div_by1");
        do_op(5'd2, 19'h7FFFF, 19'h7FFFF, 0, "mul_max");
        do_op(5'd6, 19'h0F0F0, 19'h0FF00, 5, "and_bp");
        do_op(5'd4, 19'h7FFFF, 19'd0, 0, "inc_wrap");
        do_op(5'd5, 19'd0, 19'd0, 0, "dec_wrap");
        do_op(5'd9, 19'h12345, 19'd0, 0, "not");
        do_op(5'd10, 19'd55, 19'd66, 0, "reserved");
        do_op(5'd7, 19'h50505, 19'h0A0A0, 0, "or");

        // Reset asserted 7 clocks into a MUL.
        op_in = 5'd2; a_in = 19'd1234; b_in = 19'd77; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 0);
        check("midrst.result", result, 0);
        check("midrst.zero", zero, 1);
        check("midrst.neg", negative, 0);
        check("midrst.carry", carry, 0);
        check("midrst.dbz", dbz, 0);
        @(posedge clk); #1;
        check("midrst.still_idle", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst.in_ready_after", in_ready, 1);
        do_op(5'd0, 19'd2, 19'd3, 0, "add_after_rst");

        // Randomized operations, including reserved opcodes and B==0.
        for (int n = 0; n < 50; n++) begin
            logic [4:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 5'($urandom_range(0, 13));
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 16));
            do_op(rop, ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d_op%0d", n, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
